// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared types and constants for the interrupt arbiter.
//   - irq_state_e  : arbiter FSM state encoding (IDLE, REQ, SERVICE)
//   - IRQ_MASK_RST : per-bit reset value of the enable mask (all sources enabled)
// ---------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Replicated to NUM_SRC bits by the user, so every source starts enabled.
  localparam logic IRQ_MASK_RST = 1'b1;

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
//   Combinational lowest-index priority encoder.
//   Ports:
//     req   in  NUM_SRC  request vector
//     valid out 1        any request bit set
//     idx   out ID_W     index of the lowest set request bit (0 when none)
// ---------------------------------------------------------------------------
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan from the top down so the lowest set index is the final assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter
//   N-source interrupt arbiter driving the core's single interrupt input.
//   Rising edges on src latch pending bits; the lowest-index pending and
//   enabled source is requested and held until irq_ack, after which further
//   requests are blocked until irq_done (mret).
//
//   Build option: define IRQ_SYNC_EN to pass every src bit through a 2-flop
//   synchroniser before edge detection (adds 2 cycles of latency). Without it
//   src must already be synchronous to clk.
//
//   Ports:
//     clk          in   1        rising-edge clock
//     reset        in   1        asynchronous, active-high; clears all state
//     src          in   NUM_SRC  raw interrupt lines, rising-edge sensitive
//     en_we        in   1        enable-mask write strobe
//     en_wdata     in   NUM_SRC  new enable mask
//     irq_ack      in   1        core took the trap (acts only in REQ)
//     irq_done     in   1        core executed mret (acts only in SERVICE)
//     interrupt    out  1        request to core, decoded from state register
//     irq_id       out  ID_W     requested / in-service source index
//     irq_pending  out  NUM_SRC  pending register
//     irq_mask     out  NUM_SRC  current enable mask
//     busy         out  1        handler in progress (SERVICE)
// ---------------------------------------------------------------------------
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               en_we,
  input  logic [NUM_SRC-1:0] en_wdata,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [NUM_SRC-1:0] irq_mask,
  output logic               busy
);

  irq_state_e         r_state;
  logic [ID_W-1:0]    r_irq_id;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_mask;

  logic [NUM_SRC-1:0] w_src_s;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_ack_take;
  logic               w_sel_valid;
  logic [ID_W-1:0]    w_sel_idx;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src_s = r_sync2;
`else
  assign w_src_s = src;
`endif

  assign w_edge     = w_src_s & ~r_prev;
  assign w_ack_take = (r_state == REQ) && irq_ack;

  // One-hot clear of the acknowledged source.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
    assign w_clr[gi] = w_ack_take && (r_irq_id == ID_W'(gi));
  end

  // Edge history, pending and mask registers. Set is applied after clear so a
  // new edge on the ack cycle keeps the bit pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
      r_pend <= '0;
      r_mask <= {NUM_SRC{IRQ_MASK_RST}};
    end else begin
      r_prev <= w_src_s;
      r_pend <= (r_pend & ~w_clr) | w_edge;
      if (en_we) begin
        r_mask <= en_wdata;
      end
    end
  end

  // Masked sources stay pending but are invisible to arbitration.
  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (r_pend & r_mask),
    .valid (w_sel_valid),
    .idx   (w_sel_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_irq_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_valid) begin
            r_irq_id <= w_sel_idx;
            r_state  <= REQ;
          end
        end
        // The request is latched; a later mask change does not withdraw it.
        REQ: begin
          if (irq_ack) begin
            r_state <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pure decodes of the state register: no input-to-output combinational path.
  assign interrupt   = (r_state == REQ);
  assign busy        = (r_state == SERVICE);
  assign irq_id      = r_irq_id;
  assign irq_pending = r_pend;
  assign irq_mask    = r_mask;

endmodule

// File: tb/tb_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irq_arbiter
//   Directed bench for irq_arbiter (NUM_SRC = 8). Expected values are written
//   by hand from the arbiter's cycle behaviour. SL is the extra source latency
//   introduced by the optional input synchroniser.
// ---------------------------------------------------------------------------
module tb_irq_arbiter;

`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] src;
  logic       en_we;
  logic [7:0] en_wdata;
  logic       irq_ack;
  logic       irq_done;
  logic       interrupt;
  logic [2:0] irq_id;
  logic [7:0] irq_pending;
  logic [7:0] irq_mask;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_arbiter #(
    .NUM_SRC (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src         (src),
    .en_we       (en_we),
    .en_wdata    (en_wdata),
    .irq_ack     (irq_ack),
    .irq_done    (irq_done),
    .interrupt   (interrupt),
    .irq_id      (irq_id),
    .irq_pending (irq_pending),
    .irq_mask    (irq_mask),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_int"},  32'(interrupt), 32'h0);
    check({tag, "_busy"}, 32'(busy),      32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    src      = 8'h00;
    en_we    = 1'b0;
    en_wdata = 8'h00;
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    repeat (3) tick();

    // Reset state
    check_idle_outputs("rst");
    check("rst_id",   32'(irq_id),      32'h0);
    check("rst_pend", 32'(irq_pending), 32'h00);
    check("rst_mask", 32'(irq_mask),    32'hFF);
    reset = 1'b0;
    repeat (2) tick();
    check("rst_noreq", 32'(interrupt), 32'h0);

    // Single source: src[3] pulse
    src = 8'h08;
    tick();
    src = 8'h00;
    repeat (SL) tick();
    check("t2_pend", 32'(irq_pending), 32'h08);
    check("t2_int0", 32'(interrupt),   32'h0);
    tick();
    check("t2_int1", 32'(interrupt), 32'h1);
    check("t2_id",   32'(irq_id),    32'h3);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t2_ack_pend", 32'(irq_pending), 32'h00);
    check("t2_ack_busy", 32'(busy),        32'h1);
    check("t2_ack_int",  32'(interrupt),   32'h0);
    check("t2_ack_id",   32'(irq_id),      32'h3);
    irq_ack = 1'b1;               // ack outside REQ must be ignored
    tick();
    irq_ack = 1'b0;
    check("t2_hold_busy", 32'(busy), 32'h1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check_idle_outputs("t2_done");

    // Two simultaneous sources: lowest index first
    src = 8'h24;
    tick();
    src = 8'h00;
    repeat (SL) tick();
    check("t3_pend", 32'(irq_pending), 32'h24);
    tick();
    check("t3_int_a", 32'(interrupt), 32'h1);
    check("t3_id_a",  32'(irq_id),    32'h2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t3_pend_a", 32'(irq_pending), 32'h20);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check_idle_outputs("t3_idle");
    tick();
    check("t3_int_b", 32'(interrupt), 32'h1);
    check("t3_id_b",  32'(irq_id),    32'h5);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check("t3_pend_end", 32'(irq_pending), 32'h00);

    // Masked source still latches pending but is not requested
    en_we    = 1'b1;
    en_wdata = 8'hFB;
    tick();
    en_we = 1'b0;
    check("t4_mask", 32'(irq_mask), 32'hFB);
    src = 8'h04;
    tick();
    src = 8'h00;
    repeat (SL + 2) tick();
    check("t4_pend",  32'(irq_pending), 32'h04);
    check("t4_noint", 32'(interrupt),   32'h0);
    irq_ack = 1'b1;               // ignored in IDLE
    tick();
    irq_ack = 1'b0;
    check("t4_ack_idle", 32'(irq_pending), 32'h04);
    en_we    = 1'b1;
    en_wdata = 8'hFF;
    tick();
    en_we = 1'b0;
    check("t4_mask_ff", 32'(irq_mask),  32'hFF);
    check("t4_int0",    32'(interrupt), 32'h0);
    tick();
    check("t4_int1", 32'(interrupt), 32'h1);
    check("t4_id",   32'(irq_id),    32'h2);
    irq_done = 1'b1;              // ignored in REQ
    tick();
    irq_done = 1'b0;
    check("t4_done_req", 32'(interrupt), 32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;

    // Held level does not re-trigger
    src = 8'h02;
    repeat (SL + 2) tick();
    check("t5_lvl_int", 32'(interrupt), 32'h1);
    check("t5_lvl_id",  32'(irq_id),    32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    repeat (2) tick();
    check("t5_lvl_noreq", 32'(interrupt),   32'h0);
    check("t5_lvl_pend",  32'(irq_pending), 32'h00);
    src = 8'h00;
    repeat (SL + 1) tick();

    // New edge lands on the ack edge: set wins over clear
    src = 8'h02;
    tick();
    src = 8'h00;
    repeat (SL + 1) tick();
    check("t5_int", 32'(interrupt), 32'h1);
    check("t5_id",  32'(irq_id),    32'h1);
    src = 8'h02;
    for (int i = 0; i <= SL; i++) begin
      if (i == SL) irq_ack = 1'b1;
      tick();
      src = 8'h00;
    end
    irq_ack = 1'b0;
    check("t5_setwins_pend", 32'(irq_pending), 32'h02);
    check("t5_setwins_busy", 32'(busy),        32'h1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check_idle_outputs("t5_idle");
    tick();
    check("t5_rereq_int", 32'(interrupt), 32'h1);
    check("t5_rereq_id",  32'(irq_id),    32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;

    // Asynchronous reset while in SERVICE with three bits pending
    en_we    = 1'b1;
    en_wdata = 8'h7F;
    tick();
    en_we = 1'b0;
    src = 8'h1A;
    tick();
    src = 8'h00;
    repeat (SL + 1) tick();
    check("t6_id", 32'(irq_id), 32'h1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    src = 8'h01;
    tick();
    src = 8'h00;
    repeat (SL) tick();
    check("t6_pend3", 32'(irq_pending), 32'h19);
    check("t6_busy",  32'(busy),        32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_busy", 32'(busy),        32'h0);
    check("t6_async_int",  32'(interrupt),   32'h0);
    check("t6_async_pend", 32'(irq_pending), 32'h00);
    check("t6_async_mask", 32'(irq_mask),    32'hFF);
    check("t6_async_id",   32'(irq_id),      32'h0);
    #2;
    reset = 1'b0;
    repeat (SL + 3) tick();
    check("t6_noreq", 32'(interrupt), 32'h0);

    // Reset while a request is outstanding drops interrupt at once
    src = 8'h40;
    tick();
    src = 8'h00;
    repeat (SL + 1) tick();
    check("t6_req_id", 32'(irq_id), 32'h6);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req_drop", 32'(interrupt), 32'h0);
    #2;
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
